// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, S-box tables and FSM state type for the PRESENT key schedule
// Purpose: common definitions imported by present_key_step and present_key_sched.
// Contents: RK_W (round-key width), ROT (schedule rotation amount),
//           PRESENT_SBOX / PRESENT_INV_SBOX lookup tables, key_fsm_t states.
package present_pkg;

  localparam int RK_W = 64;
  localparam int ROT  = 61;

  localparam logic [3:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] PRESENT_INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    EMIT = 2'd2
  } key_fsm_t;

endpackage

// File: rtl/present_key_step.sv
// rtl/present_key_step.sv - one combinational PRESENT key-schedule update, forward or inverse
// Purpose: computes the next key-register value from the current one.
// Ports:
//   i_s   [KEY_W-1:0]  current key register
//   i_c   [4:0]        round counter mixed into the register
//   i_inv              0 = forward update, 1 = exact inverse of the forward update
//   o_s   [KEY_W-1:0]  updated key register
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] i_s,
  input  logic [4:0]       i_c,
  input  logic             i_inv,
  output logic [KEY_W-1:0] o_s
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_key_step: KEY_W must be 80 or 128");
  end

  // Counter lands just below the S-boxed region: bits [19:15] or [66:62].
  localparam int XLO = (KEY_W == 128) ? 62 : 15;
  // 128-bit keys substitute the top two nibbles, 80-bit keys only one.
  localparam int NSB = (KEY_W == 128) ? 2 : 1;

  logic [KEY_W-1:0] w_rol;
  logic [KEY_W-1:0] w_fsb;
  logic [KEY_W-1:0] w_fwd;
  logic [KEY_W-1:0] w_ixr;
  logic [KEY_W-1:0] w_isb;
  logic [KEY_W-1:0] w_inv;

  assign w_rol = {i_s[KEY_W-ROT-1:0], i_s[KEY_W-1:KEY_W-ROT]};

  always_comb begin
    w_fsb = w_rol;
    for (int n = 0; n < NSB; n++) begin
      w_fsb[KEY_W-1-4*n -: 4] = PRESENT_SBOX[w_rol[KEY_W-1-4*n -: 4]];
    end
    w_fwd = w_fsb;
    w_fwd[XLO +: 5] = w_fsb[XLO +: 5] ^ i_c;
  end

  // Inverse undoes the forward operations in reverse order.
  always_comb begin
    w_ixr = i_s;
    w_ixr[XLO +: 5] = i_s[XLO +: 5] ^ i_c;
    w_isb = w_ixr;
    for (int n = 0; n < NSB; n++) begin
      w_isb[KEY_W-1-4*n -: 4] = PRESENT_INV_SBOX[w_ixr[KEY_W-1-4*n -: 4]];
    end
  end

  assign w_inv = {w_isb[ROT-1:0], w_isb[KEY_W-1:ROT]};
  assign o_s   = i_inv ? w_inv : w_fwd;

endmodule

// File: rtl/present_key_sched.sv
// rtl/present_key_sched.sv - sequential PRESENT round-key generator, ascending or descending order
// Purpose: loads an 80/128-bit master key and streams round keys K1..K(ROUNDS+1)
//          (encrypt) or K(ROUNDS+1)..K1 (decrypt), one per handshake.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_key_in, i_dec_mode  master key and direction, sampled on load handshake
//   i_load_valid          load request; o_load_ready high only while idle
//   o_rk, o_rk_idx        current round key and its index
//   o_rk_last             current key is the final one of the schedule
//   o_rk_valid, i_rk_ready round-key handshake
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31,
  parameter int IDX_W  = $clog2(ROUNDS + 2)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [KEY_W-1:0] i_key_in,
  input  logic             i_dec_mode,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic [RK_W-1:0]  o_rk,
  output logic [IDX_W-1:0] o_rk_idx,
  output logic             o_rk_last,
  output logic             o_rk_valid,
  input  logic             i_rk_ready
);

  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_key_sched: ROUNDS must be in 1..31");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS + 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [4:0]       LAST_C   = 5'(ROUNDS);

  key_fsm_t         r_fsm;
  logic [KEY_W-1:0] r_key;
  logic             r_dec;
  logic [4:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;

  key_fsm_t         w_fsm_nxt;
  logic [KEY_W-1:0] w_key_nxt;
  logic             w_dec_nxt;
  logic [4:0]       w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [4:0]       w_step_c;
  logic             w_step_inv;
  logic [KEY_W-1:0] w_step_s;
  logic             w_last;

  present_key_step #(.KEY_W(KEY_W)) u_step (
    .i_s   (r_key),
    .i_c   (w_step_c),
    .i_inv (w_step_inv),
    .o_s   (w_step_s)
  );

  assign w_last = (r_fsm == EMIT) && (r_dec ? (r_idx == ONE_IDX) : (r_idx == LAST_IDX));

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_key_nxt  = r_key;
    w_dec_nxt  = r_dec;
    w_cnt_nxt  = r_cnt;
    w_idx_nxt  = r_idx;
    w_step_c   = r_cnt;
    w_step_inv = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (i_load_valid) begin
          w_key_nxt = i_key_in;
          w_dec_nxt = i_dec_mode;
          w_cnt_nxt = 5'd1;
          if (i_dec_mode) begin
            w_fsm_nxt = PREP;
          end else begin
            w_fsm_nxt = EMIT;
            w_idx_nxt = ONE_IDX;
          end
        end
      end
      PREP: begin
        // Walk forward to the final key so decryption can start from it.
        w_key_nxt = w_step_s;
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt == LAST_C) begin
          w_fsm_nxt = EMIT;
          w_idx_nxt = LAST_IDX;
        end
      end
      EMIT: begin
        if (i_rk_ready) begin
          if (w_last) begin
            w_fsm_nxt = IDLE;
          end else if (r_dec) begin
            // K(i) -> K(i-1) undoes the forward step that used counter i-1.
            w_step_c   = 5'(r_idx) - 5'd1;
            w_step_inv = 1'b1;
            w_key_nxt  = w_step_s;
            w_idx_nxt  = r_idx - ONE_IDX;
          end else begin
            w_step_c  = 5'(r_idx);
            w_key_nxt = w_step_s;
            w_idx_nxt = r_idx + ONE_IDX;
          end
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm <= IDLE;
      r_key <= '0;
      r_dec <= 1'b0;
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_key <= w_key_nxt;
      r_dec <= w_dec_nxt;
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  assign o_load_ready = (r_fsm == IDLE);
  assign o_rk_valid   = (r_fsm == EMIT);
  assign o_rk_last    = w_last;
  assign o_rk_idx     = r_idx;
  assign o_rk         = r_key[KEY_W-1 -: RK_W];

endmodule

// File: tb/tb_present_key_sched.sv
// tb/tb_present_key_sched.sv - directed self-checking bench for present_key_sched (80- and 128-bit)
module tb_present_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [79:0]  a_key;
  logic         a_dec, a_lv, a_lr, a_last, a_valid, a_ready;
  logic [63:0]  a_rk;
  logic [5:0]   a_idx;

  logic [127:0] b_key;
  logic         b_dec, b_lv, b_lr, b_last, b_valid, b_ready;
  logic [63:0]  b_rk;
  logic [5:0]   b_idx;

  present_key_sched #(.KEY_W(80), .ROUNDS(31)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_key_in(a_key), .i_dec_mode(a_dec),
    .i_load_valid(a_lv), .o_load_ready(a_lr), .o_rk(a_rk), .o_rk_idx(a_idx),
    .o_rk_last(a_last), .o_rk_valid(a_valid), .i_rk_ready(a_ready)
  );

  present_key_sched #(.KEY_W(128), .ROUNDS(31)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_key_in(b_key), .i_dec_mode(b_dec),
    .i_load_valid(b_lv), .o_load_ready(b_lr), .o_rk(b_rk), .o_rk_idx(b_idx),
    .o_rk_last(b_last), .o_rk_valid(b_valid), .i_rk_ready(b_ready)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] ref_k [1:32];
  logic [63:0] got_k [1:32];
  logic [79:0] key;
  int          lat, nhs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the load edge.
  task automatic load_a(input logic [79:0] k, input logic dec);
    check("load_ready_idle", 64'(a_lr), 64'd1);
    a_key = k;
    a_dec = dec;
    a_lv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_lv  = 1'b0;
  endtask

  task automatic collect_a(input logic dec, input logic bp, input logic pulse,
                           output int o_lat, output int o_nhs);
    logic [63:0] prev_rk;
    logic [5:0]  prev_idx;
    logic        stalled;
    logic        done;
    o_lat    = 0;
    o_nhs    = 0;
    stalled  = 1'b0;
    done     = 1'b0;
    prev_rk  = '0;
    prev_idx = '0;
    for (int i = 1; i <= 32; i++) got_k[i] = 'x;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      a_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse) begin
        a_lv  = cyc[0];
        a_key = ~a_key;
        check("load_ready_busy", 64'(a_lr), 64'd0);
      end
      if (a_valid) begin
        if (o_lat == 0) o_lat = cyc;
        if (stalled) begin
          check("stall_rk", a_rk, prev_rk);
          check("stall_idx", 64'(a_idx), 64'(prev_idx));
        end
        if (a_ready) begin
          o_nhs++;
          check("hs_idx", 64'(a_idx), 64'(dec ? 33 - o_nhs : o_nhs));
          check("hs_last", 64'(a_last), 64'(o_nhs == 32));
          if (a_idx >= 6'd1 && a_idx <= 6'd32) got_k[a_idx] = a_rk;
          if (a_last) done = 1'b1;
        end
        stalled  = !a_ready;
        prev_rk  = a_rk;
        prev_idx = a_idx;
      end
      @(posedge clk);
      @(negedge clk);
    end
    a_lv    = 1'b0;
    a_ready = 1'b0;
    if (!done) check("collect_timeout", 64'd0, 64'd1);
    check("end_valid", 64'(a_valid), 64'd0);
    check("end_load_ready", 64'(a_lr), 64'd1);
  endtask

  task automatic cmp_ref(input string tag);
    for (int i = 1; i <= 32; i++) check(tag, got_k[i], ref_k[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_key = '0; a_dec = 1'b0; a_lv = 1'b0; a_ready = 1'b0;
    b_key = '0; b_dec = 1'b0; b_lv = 1'b0; b_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_a", 64'(a_valid), 64'd0);
    check("rst_last_a", 64'(a_last), 64'd0);
    check("rst_idx_a", 64'(a_idx), 64'd0);
    check("rst_ready_a", 64'(a_lr), 64'd1);
    check("rst_rk_a", a_rk, 64'd0);
    check("rst_valid_b", 64'(b_valid), 64'd0);
    check("rst_ready_b", 64'(b_lr), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // 80-bit zero key, encrypt, known leading round keys
    load_a(80'd0, 1'b0);
    collect_a(1'b0, 1'b0, 1'b0, lat, nhs);
    check("enc0_latency", 64'(lat), 64'd1);
    check("enc0_count", 64'(nhs), 64'd32);
    check("enc0_k1", got_k[1], 64'h0000000000000000);
    check("enc0_k2", got_k[2], 64'hC000000000000000);
    check("enc0_k3", got_k[3], 64'h5000180000000001);

    // 128-bit zero key, encrypt
    b_key = '0; b_dec = 1'b0; b_lv = 1'b1; b_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_lv = 1'b0;
    check("b_k1_valid", 64'(b_valid), 64'd1);
    check("b_k1", b_rk, 64'd0);
    check("b_k1_idx", 64'(b_idx), 64'd1);
    check("b_k1_last", 64'(b_last), 64'd0);
    b_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b_k2", b_rk, 64'hCC00000000000000);
    check("b_k2_idx", 64'(b_idx), 64'd2);
    for (int i = 0; i < 40 && b_valid; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("b_end_valid", 64'(b_valid), 64'd0);
    check("b_end_ready", 64'(b_lr), 64'd1);
    b_ready = 1'b0;

    // random keys: decrypt order must be encrypt order reversed
    for (int k = 0; k < 2; k++) begin
      key = {$urandom, $urandom, 16'($urandom)};
      load_a(key, 1'b0);
      collect_a(1'b0, 1'b0, 1'b0, lat, nhs);
      check("enc_count", 64'(nhs), 64'd32);
      check("enc_k1", got_k[1], key[79:16]);
      for (int i = 1; i <= 32; i++) ref_k[i] = got_k[i];
      load_a(key, 1'b1);
      collect_a(1'b1, 1'b0, 1'b0, lat, nhs);
      check("dec_latency", 64'(lat), 64'd32);
      check("dec_count", 64'(nhs), 64'd32);
      check("dec_k1", got_k[1], key[79:16]);
      cmp_ref("dec_vs_enc");
    end

    // random backpressure
    load_a(key, 1'b0);
    collect_a(1'b0, 1'b1, 1'b0, lat, nhs);
    check("bp_count", 64'(nhs), 64'd32);
    cmp_ref("bp_vs_ref");

    // load_valid pulsed while busy
    load_a(key, 1'b1);
    collect_a(1'b1, 1'b0, 1'b1, lat, nhs);
    check("pulse_latency", 64'(lat), 64'd32);
    check("pulse_count", 64'(nhs), 64'd32);
    cmp_ref("pulse_vs_ref");

    // reset during PREP
    load_a(key, 1'b1);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("prep_busy_valid", 64'(a_valid), 64'd0);
    check("prep_busy_ready", 64'(a_lr), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_prep_valid", 64'(a_valid), 64'd0);
    check("rst_prep_ready", 64'(a_lr), 64'd1);
    check("rst_prep_idx", 64'(a_idx), 64'd0);

    // reset during EMIT at idx 5, with rk_ready also high
    load_a(key, 1'b0);
    a_ready = 1'b1;
    for (int i = 0; i < 40 && a_idx != 6'd5; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("emit_idx5", 64'(a_idx), 64'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_ready = 1'b0;
    check("rst_emit_valid", 64'(a_valid), 64'd0);
    check("rst_emit_ready", 64'(a_lr), 64'd1);
    check("rst_emit_last", 64'(a_last), 64'd0);
    check("rst_emit_idx", 64'(a_idx), 64'd0);

    // fresh schedule after reset
    load_a(key, 1'b1);
    collect_a(1'b1, 1'b0, 1'b0, lat, nhs);
    check("fresh_latency", 64'(lat), 64'd32);
    check("fresh_count", 64'(nhs), 64'd32);
    cmp_ref("fresh_vs_ref");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
